// File: rtl/board_snapshot_reader_if.sv
// Row-beat stream carrying one captured board per frame from board_snapshot_reader
// to a display/UART/host sink.
interface board_snapshot_reader_if #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 16,
    parameter int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_row_data;
    logic [ROW_W-1:0] out_row_idx;
    logic             out_last;
    logic [GEN_W-1:0] out_gen;
    logic             out_extinct;
    logic             out_stable;

    modport master (
        output out_valid, out_row_data, out_row_idx, out_last,
               out_gen, out_extinct, out_stable,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_row_data, out_row_idx, out_last,
               out_gen, out_extinct, out_stable,
        output out_ready
    );
endinterface

// File: rtl/board_snapshot_reader.sv
// Samples the cell array once per generation (phase 1 of the shared element phase
// sequence) and streams the captured board out row by row.
//
//  state  | meaning
//  IDLE   | no frame held; next tick with enable captures the board
//  STREAM | frame buffer valid; presenting row row_q, advance on handshake
module board_snapshot_reader #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [WIDTH*HEIGHT-1:0]   board,
    board_snapshot_reader_if.master   stream,
    output logic [7:0]                dropped
);
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
    localparam logic [2:0] PHASE_SAMPLE = 3'd1;
    localparam logic [2:0] PHASE_END    = 3'd7;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                    state_q, state_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [2:0]                phase_q;
    logic [GEN_W-1:0]          gen_q;
    logic [WIDTH*HEIGHT-1:0]   prev_board_q;
    logic                      prev_ok_q;
    logic [7:0]                dropped_q;

    logic [WIDTH*HEIGHT-1:0]   buf_board_q;
    logic [GEN_W-1:0]          buf_gen_q;
    logic                      buf_extinct_q;
    logic                      buf_stable_q;

    logic tick;
    logic still;
    logic extinct;
    logic handshake;
    logic capture;
    logic drop;

    assign tick      = (phase_q == PHASE_SAMPLE);
    assign still     = prev_ok_q && (board == prev_board_q);
    assign extinct   = (board == '0);
    assign handshake = (state_q == STREAM) && stream.out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        capture = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    capture = 1'b1;
                    state_d = STREAM;
                    row_d   = '0;
                end
            end
            STREAM: begin
                // A tick while a frame is still in flight is lost, even on the final handshake.
                if (tick && enable) begin
                    drop = 1'b1;
                end
                if (handshake) begin
                    if (row_q == LAST_ROW) begin
                        state_d = IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
            end
        endcase
    end

    // Phase counter tracks the element FSM: 0 once after reset, then 1..7 repeating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= '0;
        end else if (phase_q == 3'd0 || phase_q == PHASE_END) begin
            phase_q <= PHASE_SAMPLE;
        end else begin
            phase_q <= phase_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gen_q        <= '0;
            prev_board_q <= '0;
            prev_ok_q    <= 1'b0;
        end else if (tick) begin
            gen_q        <= gen_q + GEN_W'(1);
            prev_board_q <= board;
            prev_ok_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dropped_q <= '0;
        end else if (drop && dropped_q != 8'hFF) begin
            dropped_q <= dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_board_q   <= '0;
            buf_gen_q     <= '0;
            buf_extinct_q <= 1'b0;
            buf_stable_q  <= 1'b0;
        end else if (capture) begin
            buf_board_q   <= board;
            buf_gen_q     <= gen_q;
            buf_extinct_q <= extinct;
            buf_stable_q  <= still;
        end
    end

    assign stream.out_valid    = (state_q == STREAM);
    assign stream.out_row_data = buf_board_q[row_q*WIDTH +: WIDTH];
    assign stream.out_row_idx  = row_q;
    assign stream.out_last     = (state_q == STREAM) && (row_q == LAST_ROW);
    assign stream.out_gen      = buf_gen_q;
    assign stream.out_extinct  = buf_extinct_q;
    assign stream.out_stable   = buf_stable_q;
    assign dropped             = dropped_q;
endmodule
